// File: rtl/lin_approx_ctrl_if.sv
// ---------------------------------------------------------------------------
// lin_approx_ctrl_if
// Plaintext-out / ciphertext-back link between the linear-approximation
// controller and an external pipelined cipher core.
//   pt_data / pt_valid : plaintext offered by the controller
//   pt_ready           : cipher accepts (transfer = pt_valid & pt_ready)
//   ct_data / ct_valid : ciphertext returned in issue order, never stalled
// Modports: master = controller side, slave = cipher side.
// ---------------------------------------------------------------------------
interface lin_approx_ctrl_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] pt_data;
    logic              pt_valid;
    logic              pt_ready;
    logic [DATA_W-1:0] ct_data;
    logic              ct_valid;

    modport master (
        output pt_data,
        output pt_valid,
        input  pt_ready,
        input  ct_data,
        input  ct_valid
    );

    modport slave (
        input  pt_data,
        input  pt_valid,
        output pt_ready,
        output ct_data,
        output ct_valid
    );
endinterface

// File: rtl/lin_approx_ctrl.sv
// ---------------------------------------------------------------------------
// lin_approx_ctrl
// Linear-approximation experiment controller. Generates plaintexts from an
// LFSR, streams them to a pipelined cipher core, matches the in-order
// ciphertexts against the remembered plaintexts and counts, for each of
// NUM_MASKS mask pairs, how often parity(pt&mi) == parity(ct&mo).
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   start              : begin a run (accepted in IDLE or DONE)
//   restart_block      : abort to IDLE, priority over start
//   seed, polynomial   : LFSR start value and feedback taps (sampled at start)
//   counter_limit      : plaintexts per run (sampled at start)
//   mask_i, mask_o     : packed mask pairs, pair k at [k*DATA_W +: DATA_W]
//   cipher             : pt/ct link (master modport)
//   counters           : packed match counts, pair k at [k*CNT_W +: CNT_W]
//   issued             : plaintexts transferred this run
//   done               : high while in DONE
// ---------------------------------------------------------------------------
module lin_approx_ctrl #(
    parameter int DATA_W       = 64,
    parameter int CNT_W        = 64,
    parameter int NUM_MASKS    = 4,
    parameter int MAX_INFLIGHT = 16   // power of two, >= 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          restart_block,
    input  logic [DATA_W-1:0]             seed,
    input  logic [DATA_W-1:0]             polynomial,
    input  logic [CNT_W-1:0]              counter_limit,
    input  logic [NUM_MASKS*DATA_W-1:0]   mask_i,
    input  logic [NUM_MASKS*DATA_W-1:0]   mask_o,
    lin_approx_ctrl_if.master             cipher,
    output logic [NUM_MASKS*CNT_W-1:0]    counters,
    output logic [CNT_W-1:0]              issued,
    output logic                          done
);
    localparam int AW  = $clog2(MAX_INFLIGHT);
    localparam int OW  = AW + 1;        // holds 0..MAX_INFLIGHT
    localparam int OW1 = OW + 1;        // headroom for fifo + stale sums
    localparam logic [OW:0] MAX_V = OW1'(MAX_INFLIGHT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                      state_q;
    logic                        done_q;
    logic [DATA_W-1:0]           lfsr_q;
    logic [DATA_W-1:0]           poly_q;
    logic [CNT_W-1:0]            limit_q;
    logic [CNT_W-1:0]            issued_q;
    logic [CNT_W-1:0]            retired_q;
    logic [NUM_MASKS*DATA_W-1:0] mask_i_q;
    logic [NUM_MASKS*DATA_W-1:0] mask_o_q;

    // In-flight plaintext buffer. Shallow, so the head is read directly:
    // the retiring ciphertext must be matched in the same cycle it arrives.
    logic [DATA_W-1:0]           fifo_mem [MAX_INFLIGHT];
    logic [AW-1:0]               wr_ptr_q;
    logic [AW-1:0]               rd_ptr_q;
    logic [OW-1:0]               fifo_cnt_q;
    // Ciphertexts still owed by the cipher for aborted runs; they arrive
    // before any item of the current run and are dropped.
    logic [OW-1:0]               stale_q;

    logic [OW:0]                 inflight;
    logic [OW:0]                 stale_flush;
    logic                        pt_valid_int;
    logic                        push;
    logic                        pop;
    logic                        stale_hit;
    logic                        abort;
    logic                        launch;
    logic                        flush;
    logic [DATA_W-1:0]           head;
    logic [DATA_W-1:0]           lfsr_next;
    logic [NUM_MASKS-1:0]        match;

    assign inflight     = {1'b0, fifo_cnt_q} + {1'b0, stale_q};
    assign pt_valid_int = (state_q == S_RUN) && (issued_q < limit_q) && (inflight < MAX_V);
    assign push         = pt_valid_int && cipher.pt_ready;
    assign stale_hit    = cipher.ct_valid && (stale_q != '0);
    assign pop          = cipher.ct_valid && (stale_q == '0) && (fifo_cnt_q != '0);
    assign head         = fifo_mem[rd_ptr_q];
    assign lfsr_next    = {lfsr_q[DATA_W-2:0], ^(lfsr_q & poly_q)};

    assign abort  = restart_block;
    assign launch = start && !restart_block && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign flush  = abort || launch;

    // Everything still owed by the cipher becomes stale on a flush,
    // including a transfer happening this very cycle, minus whatever
    // ciphertext comes back this cycle.
    assign stale_flush = inflight + {{OW{1'b0}}, push} - {{OW{1'b0}}, (stale_hit || pop)};

    assign cipher.pt_data  = lfsr_q;
    assign cipher.pt_valid = pt_valid_int;
    assign issued          = issued_q;
    assign done            = done_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= lfsr_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASKS; gi++) begin : g_mask
            logic [CNT_W-1:0] cnt_q;

            assign match[gi] = ~^((head & mask_i_q[gi*DATA_W +: DATA_W]) ^
                                  (cipher.ct_data & mask_o_q[gi*DATA_W +: DATA_W]));

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    cnt_q <= '0;
                end else if (pop && match[gi]) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign counters[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            lfsr_q     <= '0;
            poly_q     <= '0;
            limit_q    <= '0;
            mask_i_q   <= '0;
            mask_o_q   <= '0;
            issued_q   <= '0;
            retired_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            stale_q    <= '0;
        end else begin
            if (flush) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                fifo_cnt_q <= '0;
                stale_q    <= stale_flush[OW-1:0];
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push && !pop) begin
                    fifo_cnt_q <= fifo_cnt_q + 1'b1;
                end else if (!push && pop) begin
                    fifo_cnt_q <= fifo_cnt_q - 1'b1;
                end
                if (stale_hit) stale_q <= stale_q - 1'b1;
            end

            if (push) lfsr_q <= lfsr_next;

            if (abort) begin
                state_q   <= S_IDLE;
                done_q    <= 1'b0;
                issued_q  <= '0;
                retired_q <= '0;
            end else if (launch) begin
                lfsr_q    <= seed;
                poly_q    <= polynomial;
                limit_q   <= counter_limit;
                mask_i_q  <= mask_i;
                mask_o_q  <= mask_o;
                issued_q  <= '0;
                retired_q <= '0;
                if (counter_limit == '0) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= S_RUN;
                    done_q  <= 1'b0;
                end
            end else begin
                if (push) issued_q  <= issued_q + 1'b1;
                if (pop)  retired_q <= retired_q + 1'b1;
                case (state_q)
                    S_RUN: begin
                        if (push && (issued_q + 1'b1 == limit_q)) state_q <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        // The last item can only retire after it was issued,
                        // so completion is only looked for here.
                        if (pop && (retired_q + 1'b1 == limit_q)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lin_approx_ctrl.sv
module tb_lin_approx_ctrl;
    localparam int DATA_W       = 64;
    localparam int CNT_W        = 32;
    localparam int NUM_MASKS    = 4;
    localparam int MAX_INFLIGHT = 4;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        start = 1'b0;
    logic                        restart_block = 1'b0;
    logic [DATA_W-1:0]           seed = '0;
    logic [DATA_W-1:0]           polynomial = '0;
    logic [CNT_W-1:0]            counter_limit = '0;
    logic [NUM_MASKS*DATA_W-1:0] mask_i = '0;
    logic [NUM_MASKS*DATA_W-1:0] mask_o = '0;
    logic [NUM_MASKS*CNT_W-1:0]  counters;
    logic [CNT_W-1:0]            issued;
    logic                        done;

    lin_approx_ctrl_if #(.DATA_W(DATA_W)) cif ();

    lin_approx_ctrl #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .NUM_MASKS(NUM_MASKS), .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .restart_block(restart_block),
        .seed(seed), .polynomial(polynomial), .counter_limit(counter_limit),
        .mask_i(mask_i), .mask_o(mask_o), .cipher(cif),
        .counters(counters), .issued(issued), .done(done)
    );

    always #5 clk = ~clk;

    // Cipher model: fixed-latency delay line; each slot remembers the
    // plaintext it carries and which run (epoch) issued it.
    typedef struct {
        bit                v;
        logic [DATA_W-1:0] pt;
        int                ep;
    } slot_t;

    slot_t             pipe[$];
    int                lat;
    bit                cmode;
    logic [DATA_W-1:0] ckey;
    int                rdy_mode;   // 0 always, 1 toggle, 2 random, 3 never

    // Reference model of the experiment: 0 idle, 1 running, 2 done.
    int                m_mode;
    int                epoch;
    logic [DATA_W-1:0] m_lfsr, m_poly;
    longint            m_limit, m_issued, m_retired;
    logic [DATA_W-1:0] m_mi[NUM_MASKS];
    logic [DATA_W-1:0] m_mo[NUM_MASKS];
    longint            m_cnt[NUM_MASKS];
    logic [DATA_W-1:0] xfer_log[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] cipher_f(input logic [DATA_W-1:0] p);
        if (!cmode) return p;
        return {p[DATA_W-9:0], p[DATA_W-1 -: 8]} ^ ckey;
    endfunction

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] p);
        return {x[DATA_W-2:0], ^(x & p)};
    endfunction

    function automatic int outst();
        int c = 0;
        foreach (pipe[i]) if (pipe[i].v) c++;
        return c;
    endfunction

    function automatic logic [NUM_MASKS*CNT_W-1:0] pack_cnt();
        logic [NUM_MASKS*CNT_W-1:0] r;
        for (int k = 0; k < NUM_MASKS; k++) r[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
        return r;
    endfunction

    task automatic set_lat(input int l);
        slot_t e;
        e.v = 0; e.pt = '0; e.ep = 0;
        pipe.delete();
        lat = l;
        for (int i = 0; i < l; i++) pipe.push_back(e);
    endtask

    // One clock cycle: drive cipher outputs, check DUT against the model,
    // then advance the model by the edge that ends this cycle.
    task automatic cycle();
        slot_t             front, nw;
        int                o, mode_before;
        bit                xfer, ok;
        logic [DATA_W-1:0] ct;
        o     = outst();
        front = pipe.pop_front();
        ct    = cipher_f(front.pt);
        cif.ct_valid = front.v;
        cif.ct_data  = front.v ? ct : {$urandom, $urandom};
        case (rdy_mode)
            0:       cif.pt_ready = 1'b1;
            1:       cif.pt_ready = ~cif.pt_ready;
            2:       cif.pt_ready = 1'($urandom_range(0, 1));
            default: cif.pt_ready = 1'b0;
        endcase
        #1;
        chk("pt_valid", cif.pt_valid, (m_mode == 1) && (m_issued < m_limit) && (o < MAX_INFLIGHT));
        chk("pt_data", cif.pt_data, m_lfsr);
        chk("issued", issued, m_issued);
        chk("counters", counters, pack_cnt());
        chk("done", done, m_mode == 2);
        chk("inflight_cap", o <= MAX_INFLIGHT, 1'b1);

        xfer  = cif.pt_valid && cif.pt_ready;
        nw.v  = xfer; nw.pt = cif.pt_data; nw.ep = epoch;
        if (xfer) xfer_log.push_back(cif.pt_data);
        mode_before = m_mode;
        if (rst) begin
            m_mode = 0; m_lfsr = '0; m_poly = '0; m_limit = 0;
            m_issued = 0; m_retired = 0;
            foreach (m_cnt[k]) m_cnt[k] = 0;
            epoch++;
            set_lat(lat);
        end else begin
            pipe.push_back(nw);
            if (xfer) begin
                m_lfsr = lfsr_step(m_lfsr, m_poly);
                m_issued++;
            end
            if (front.v && front.ep == epoch && m_mode == 1) begin
                for (int k = 0; k < NUM_MASKS; k++) begin
                    ok = ((^(front.pt & m_mi[k])) ^ (^(ct & m_mo[k]))) == 1'b0;
                    if (ok) m_cnt[k]++;
                end
                m_retired++;
                if (m_retired == m_limit) m_mode = 2;
            end
            if (restart_block) begin
                m_mode = 0; m_issued = 0; m_retired = 0;
                foreach (m_cnt[k]) m_cnt[k] = 0;
                epoch++;
            end else if (start && mode_before != 1) begin
                epoch++;
                m_lfsr = seed; m_poly = polynomial; m_limit = longint'(counter_limit);
                m_issued = 0; m_retired = 0;
                for (int k = 0; k < NUM_MASKS; k++) begin
                    m_cnt[k] = 0;
                    m_mi[k]  = mask_i[k*DATA_W +: DATA_W];
                    m_mo[k]  = mask_o[k*DATA_W +: DATA_W];
                end
                m_mode = (counter_limit == '0) ? 2 : 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic launch(input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] p,
                          input logic [CNT_W-1:0] lim,
                          input logic [NUM_MASKS*DATA_W-1:0] mi,
                          input logic [NUM_MASKS*DATA_W-1:0] mo);
        seed = s; polynomial = p; counter_limit = lim; mask_i = mi; mask_o = mo;
        xfer_log.delete();
        start = 1'b1;
        cycle();
        start = 1'b0;
        // Later input changes must not affect the run.
        seed = {$urandom, $urandom}; polynomial = {$urandom, $urandom};
        counter_limit = CNT_W'($urandom_range(0, 50));
        for (int k = 0; k < NUM_MASKS; k++) begin
            mask_i[k*DATA_W +: DATA_W] = {$urandom, $urandom};
            mask_o[k*DATA_W +: DATA_W] = {$urandom, $urandom};
        end
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (m_mode != 2 && n < budget) begin
            cycle();
            n++;
        end
        chk("run_completes", m_mode == 2, 1'b1);
    endtask

    task automatic drain_pipe();
        int n = 0;
        while (outst() > 0 && n < 200) begin
            cycle();
            n++;
        end
        chk("pipe_drains", outst() == 0, 1'b1);
    endtask

    logic [NUM_MASKS*DATA_W-1:0] mi_t, mo_t;
    logic [NUM_MASKS*CNT_W-1:0]  ref_a, ref5;
    logic [DATA_W-1:0]           poly_a, seed5;
    int                          pv_seen, n;

    initial begin
        cif.pt_ready = 1'b0; cif.ct_valid = 1'b0; cif.ct_data = '0;
        cmode = 0; ckey = '0; rdy_mode = 0; epoch = 0;
        m_mode = 0; m_lfsr = '0; m_poly = '0; m_limit = 0; m_issued = 0; m_retired = 0;
        foreach (m_cnt[k]) begin m_cnt[k] = 0; m_mi[k] = '0; m_mo[k] = '0; end
        set_lat(3);
        @(negedge clk);
        rst = 1'b1; cycle(); cycle(); rst = 1'b0;
        chk("rst_pt_valid", cif.pt_valid, 1'b0);
        chk("rst_pt_data", cif.pt_data, 0);
        chk("rst_counters", counters, 0);
        chk("rst_issued", issued, 0);
        chk("rst_done", done, 1'b0);

        // Identity cipher, latency 3, nine plaintexts.
        mi_t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        mo_t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        mi_t[63:0] = 64'h2104008000000000; mo_t[63:0] = 64'h2104008000000000;
        mi_t[127:64] = 64'h1; mo_t[127:64] = 64'h0;
        launch(64'h1, 64'h1, 9, mi_t, mo_t);
        run_until_done(200);
        chk("t1_xfers", xfer_log.size(), 9);
        chk("t1_first_pt", xfer_log[0], 64'h1);
        chk("t1_second_pt", xfer_log[1], 64'h3);
        chk("t1_last_pt", xfer_log[8], 64'h1FF);
        chk("t1_cnt0", counters[CNT_W-1:0], 9);
        chk("t1_cnt1", counters[2*CNT_W-1:CNT_W], 0);
        chk("t1_issued", issued, 9);
        chk("t1_done", done, 1'b1);

        // Unthrottled reference run of 20, then the same from DONE with
        // latency 10 and pt_ready toggling.
        poly_a = 64'hD800000000000000;
        mi_t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        mo_t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        launch(64'h1, poly_a, 20, mi_t, mo_t);
        run_until_done(400);
        ref_a = pack_cnt();
        set_lat(10); rdy_mode = 1;
        launch(64'h1, poly_a, 20, mi_t, mo_t);
        chk("redo_counters_clear", counters, 0);
        chk("redo_issued_clear", issued, 0);
        chk("redo_reseed", cif.pt_data, 64'h1);
        run_until_done(1000);
        chk("t2_counts_match", counters, ref_a);
        chk("t2_issued", issued, 20);

        // Zero-length run.
        rdy_mode = 0;
        launch(64'h5, poly_a, 0, mi_t, mo_t);
        chk("lim0_done", done, 1'b1);
        pv_seen = 0;
        repeat (5) begin
            if (cif.pt_valid) pv_seen++;
            cycle();
        end
        chk("lim0_no_valid", pv_seen, 0);
        chk("lim0_counters", counters, 0);

        // Clean 5-item reference, then restart with 3 in flight.
        seed5 = 64'h0123456789ABCDEF;
        launch(seed5, poly_a, 5, mi_t, mo_t);
        run_until_done(400);
        ref5 = pack_cnt();
        launch(seed5, poly_a, 20, mi_t, mo_t);
        n = 0;
        while (outst() < 3 && n < 20) begin cycle(); n++; end
        rdy_mode = 3; restart_block = 1'b1; cycle(); restart_block = 1'b0; rdy_mode = 0;
        chk("t4_inflight_at_restart", outst(), 3);
        chk("t4_restart_done_low", done, 1'b0);
        launch(seed5, poly_a, 5, mi_t, mo_t);
        run_until_done(400);
        chk("t4_counts_match", counters, ref5);

        // Reset in the middle of a run.
        launch(64'hFEED, poly_a, 20, mi_t, mo_t);
        repeat (6) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("t5_pt_valid", cif.pt_valid, 1'b0);
        chk("t5_pt_data", cif.pt_data, 0);
        chk("t5_counters", counters, 0);
        chk("t5_issued", issued, 0);
        chk("t5_done", done, 1'b0);
        launch(seed5, poly_a, 5, mi_t, mo_t);
        run_until_done(400);
        chk("t5_counts_match", counters, ref5);

        // Randomised runs with random back-pressure, aborts and ignored starts.
        for (int it = 0; it < 25; it++) begin
            drain_pipe();
            set_lat(int'($urandom_range(1, 12)));
            cmode = 1'($urandom_range(0, 1));
            ckey = {$urandom, $urandom};
            rdy_mode = 2;
            mi_t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            mo_t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            launch({$urandom, $urandom}, {$urandom, $urandom}, CNT_W'($urandom_range(1, 30)), mi_t, mo_t);
            n = 0;
            while (m_mode == 1 && n < 2000) begin
                restart_block = ($urandom_range(0, 59) == 0);
                start = ($urandom_range(0, 19) == 0);
                cycle();
                n++;
            end
            restart_block = 1'b0; start = 1'b0;
            chk("rand_run_ends", m_mode != 1, 1'b1);
        end
        drain_pipe();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
